// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   - state_e    : loader FSM states (CHK exists only with IMEM_LOADER_CHECKSUM_EN)
//   - WORD_BYTES : bytes per instruction word
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        FINISH
    } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects WORD_BYTES bytes into one big-endian word.
// Ports:
//   clk, reset   : clock, async active-high reset
//   clear        : drop any partial word and restart the byte count
//   byte_valid   : byte_in is accepted this cycle
//   byte_in      : incoming byte
//   word         : assembled word; first byte in the MSBs, byte_in in the LSBs
//   word_valid   : combinational pulse, high while the last byte of a word is accepted
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_in,
    output logic [8*WORD_BYTES-1:0]   word,
    output logic                      word_valid
);

    localparam int CW = $clog2(WORD_BYTES);
    localparam int SW = 8 * (WORD_BYTES - 1);

    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          last_byte;

    // The word is presented in the same cycle its last byte arrives so the
    // top level can register the write strobe on that very edge.
    assign word       = {shift_q, byte_in};
    assign last_byte  = (count_q == CW'(WORD_BYTES - 1));
    assign word_valid = byte_valid && last_byte;

    always_comb begin
        count_d = count_q;
        shift_d = shift_q;
        if (clear) begin
            count_d = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            if (last_byte) begin
                count_d = '0;
                shift_d = '0;
            end else begin
                count_d = count_q + 1'b1;
                shift_d = word[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            shift_q <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program over a byte stream and writes it into
// instruction memory while holding the CPU in reset.
// Stream: N[15:8], N[7:0], then N big-endian 32-bit words
//         (+ one XOR checksum byte over the payload when IMEM_LOADER_CHECKSUM_EN is defined).
// Ports:
//   clk, reset           : clock, async active-high reset
//   rx_data, rx_valid    : byte from the serial receiver and its one-cycle strobe
//   load_start           : begin a load (honoured only when idle)
//   wr_en/wr_addr/wr_data: one-cycle memory write, byte address = index*4
//   cpu_hold             : high for the duration of a load
//   done                 : one-cycle pulse at the end of a load
//   err                  : sticky; word beyond ROM_SIZE or checksum mismatch
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CHK state and payload XOR check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ROM_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        load_start,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] ROM_WORDS = 32'(ROM_SIZE);

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        asm_clear;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic        asm_word_valid;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    assign asm_clear = (state_q == IDLE) && load_start;
    assign asm_valid = (state_q == DATA) && rx_valid;
    assign last_word = (idx_q + 16'd1) == n_q;

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = HDR_HI;
                    cpu_hold_d = 1'b1;
                    err_d      = 1'b0;
                    idx_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            HDR_HI: begin
                if (rx_valid) begin
                    n_d     = {rx_data, 8'd0};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (rx_valid) begin
                    n_d = {n_q[15:8], rx_data};
                    // An empty program has no payload, hence no checksum byte.
                    state_d = ({n_q[15:8], rx_data} == 16'd0) ? FINISH : DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    if (asm_word_valid) begin
                        if ({16'd0, idx_q} < ROM_WORDS) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {14'd0, idx_q, 2'b00};
                            wr_data_d = asm_word;
                        end else begin
                            err_d = 1'b1;
                        end
                        idx_d = idx_q + 16'd1;
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = FINISH;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    if (rx_data != xor_q) err_d = 1'b1;
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances share the stimulus: dut_a with
// ROM_SIZE=128 and dut_b with ROM_SIZE=2. Expected writes/err come from a
// simple model: word i of the program goes to address 4*i if i < ROM_SIZE.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_start;

    logic        wr_en_a, cpu_hold_a, done_a, err_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic        wr_en_b, cpu_hold_b, done_b, err_b;
    logic [31:0] wr_addr_b, wr_data_b;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    imem_loader #(.ROM_SIZE(128)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .load_start(load_start), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a)
    );

    imem_loader #(.ROM_SIZE(2)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .load_start(load_start), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
    );

    // Observed writes {addr, data} and done pulses, sampled 1 ns after each edge.
    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];
    int          dcnt_a, dcnt_b;
    logic        hold_a, hold_b;
    logic [31:0] word_buf[0:7];

    always @(posedge clk) begin
        #1;
        if (wr_en_a) wq_a.push_back({wr_addr_a, wr_data_a});
        if (wr_en_b) wq_b.push_back({wr_addr_b, wr_data_b});
        if (done_a) dcnt_a++;
        if (done_b) dcnt_b++;
    end

    function automatic int exp_writes(int n, int rom);
        return (n < rom) ? n : rom;
    endfunction

    function automatic logic [63:0] exp_entry(int i);
        logic [31:0] a;
        a = 32'(i * 4);
        return {a, word_buf[i]};
    endfunction

    task automatic clear_obs();
        wq_a.delete();
        wq_b.delete();
        dcnt_a = 0;
        dcnt_b = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        hold_a = cpu_hold_a;
        hold_b = cpu_hold_b;
    endtask

    // Full load of word_buf[0..n-1]; bad_chk corrupts the checksum byte.
    task automatic load(input int n, input bit bad_chk);
        logic [7:0] x;
        logic [15:0] nn;
        x  = 8'd0;
        nn = 16'(n);
        clear_obs();
        start_load();
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) begin
                x = x ^ word_buf[i][8*k +: 8];
                send_byte(word_buf[i][8*k +: 8]);
            end
        end
        if (CHK_EN && n > 0) send_byte(bad_chk ? (x ^ 8'h01) : x);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({wr_en_a, done_a, cpu_hold_a, err_a} !== 4'b0000) $display("FAIL reset_flags_a got %b want 0000", {wr_en_a, done_a, cpu_hold_a, err_a}); else pass_cnt++;
        total_cnt++;
        if ({wr_addr_a, wr_data_a} !== 64'd0) $display("FAIL reset_bus_a got %h want 0", {wr_addr_a, wr_data_a}); else pass_cnt++;
        total_cnt++;
        if ({wr_en_b, done_b, cpu_hold_b, err_b} !== 4'b0000) $display("FAIL reset_flags_b got %b want 0000", {wr_en_b, done_b, cpu_hold_b, err_b}); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        word_buf[0] = 32'h201D0000;
        word_buf[1] = 32'h3C084000;
        load(2, 1'b0);
        total_cnt++;
        if (hold_a !== 1'b1) $display("FAIL basic_hold got %b want 1", hold_a); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() !== 2) $display("FAIL basic_nwr got %0d want 2", wq_a.size()); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() > 0 && wq_a[0] !== 64'h00000000_201D0000) $display("FAIL basic_wr0 got %h want 00000000201d0000", wq_a[0]); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() > 1 && wq_a[1] !== 64'h00000004_3C084000) $display("FAIL basic_wr1 got %h want 000000043c084000", wq_a[1]); else pass_cnt++;
        total_cnt++;
        if (dcnt_a !== 1) $display("FAIL basic_done got %0d want 1", dcnt_a); else pass_cnt++;
        total_cnt++;
        if ({cpu_hold_a, err_a, err_b} !== 3'b000) $display("FAIL basic_hold_err got %b want 000", {cpu_hold_a, err_a, err_b}); else pass_cnt++;
    endtask

    task automatic test_zero();
        clear_obs();
        start_load();
        send_byte(8'h00);
        send_byte(8'h00);
        // Header byte accepted on the previous edge; done follows one edge later.
        total_cnt++;
        if (done_a !== 1'b0) $display("FAIL zero_done_early got %b want 0", done_a); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done_a !== 1'b1) $display("FAIL zero_done got %b want 1", done_a); else pass_cnt++;
        total_cnt++;
        if (cpu_hold_a !== 1'b0) $display("FAIL zero_hold got %b want 0", cpu_hold_a); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done_a !== 1'b0) $display("FAIL zero_done_width got %b want 0", done_a); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() + wq_b.size() !== 0 || err_a !== 1'b0) $display("FAIL zero_nowr got %0d writes err=%b want 0 writes err=0", wq_a.size() + wq_b.size(), err_a); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) word_buf[i] = $urandom;
        load(3, 1'b0);
        total_cnt++;
        if (wq_b.size() !== 2) $display("FAIL ovf_nwr got %0d want 2", wq_b.size()); else pass_cnt++;
        for (int i = 0; i < wq_b.size() && i < 2; i++) begin
            total_cnt++;
            if (wq_b[i] !== exp_entry(i)) $display("FAIL ovf_wr%0d got %h want %h", i, wq_b[i], exp_entry(i)); else pass_cnt++;
        end
        total_cnt++;
        if (err_b !== 1'b1 || dcnt_b !== 1) $display("FAIL ovf_err_done got err=%b done=%0d want err=1 done=1", err_b, dcnt_b); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() !== 3 || err_a !== 1'b0) $display("FAIL ovf_big got %0d writes err=%b want 3 err=0", wq_a.size(), err_a); else pass_cnt++;
        // A new load must clear the sticky flag.
        clear_obs();
        start_load();
        total_cnt++;
        if (err_b !== 1'b0) $display("FAIL ovf_err_clear got %b want 0", err_b); else pass_cnt++;
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midload();
        logic [7:0] bytes[8];
        bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
        clear_obs();
        start_load();
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({cpu_hold_a, wr_en_a, err_a} !== 3'b000) $display("FAIL rst_mid_flags got %b want 000", {cpu_hold_a, wr_en_a, err_a}); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wq_a.size() !== 1 || cpu_hold_a !== 1'b0) $display("FAIL rst_mid_nowr got %0d writes hold=%b want 1 write hold=0", wq_a.size(), cpu_hold_a); else pass_cnt++;
        word_buf[0] = $urandom;
        load(1, 1'b0);
        total_cnt++;
        if (wq_a.size() !== 1 || (wq_a.size() > 0 && wq_a[0] !== exp_entry(0))) $display("FAIL rst_mid_fresh got n=%0d first=%h want n=1 first=%h", wq_a.size(), (wq_a.size() > 0) ? wq_a[0] : 64'd0, exp_entry(0)); else pass_cnt++;
    endtask

    task automatic test_random();
        int n;
        bit bad;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 4);
            bad = CHK_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < n; i++) word_buf[i] = $urandom;
            load(n, bad);
            total_cnt++;
            if (wq_a.size() !== exp_writes(n, 128) || wq_b.size() !== exp_writes(n, 2)) $display("FAIL rnd%0d_nwr got %0d/%0d want %0d/%0d", it, wq_a.size(), wq_b.size(), exp_writes(n, 128), exp_writes(n, 2)); else pass_cnt++;
            for (int i = 0; i < wq_a.size() && i < n; i++) begin
                total_cnt++;
                if (wq_a[i] !== exp_entry(i)) $display("FAIL rnd%0d_wr%0d got %h want %h", it, i, wq_a[i], exp_entry(i)); else pass_cnt++;
            end
            total_cnt++;
            if (err_a !== (bad && n > 0) || err_b !== ((n > 2) || (bad && n > 0))) $display("FAIL rnd%0d_err got %b/%b want %b/%b", it, err_a, err_b, bad && n > 0, (n > 2) || (bad && n > 0)); else pass_cnt++;
            total_cnt++;
            if (dcnt_a !== 1 || dcnt_b !== 1 || cpu_hold_a !== 1'b0) $display("FAIL rnd%0d_done got %0d/%0d hold=%b want 1/1 hold=0", it, dcnt_a, dcnt_b, cpu_hold_a); else pass_cnt++;
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        word_buf[0] = 32'h01020304;
        load(1, 1'b0);
        total_cnt++;
        if (err_a !== 1'b0 || dcnt_a !== 1) $display("FAIL chk_good got err=%b done=%0d want err=0 done=1", err_a, dcnt_a); else pass_cnt++;
        load(1, 1'b1);
        total_cnt++;
        if (err_a !== 1'b1 || dcnt_a !== 1) $display("FAIL chk_bad got err=%b done=%0d want err=1 done=1", err_a, dcnt_a); else pass_cnt++;
        total_cnt++;
        if (wq_a.size() !== 1 || (wq_a.size() > 0 && wq_a[0] !== 64'h00000000_01020304)) $display("FAIL chk_wr got n=%0d want 1 write of 01020304", wq_a.size()); else pass_cnt++;
    endtask
`endif

    initial begin
        rx_data = 8'd0;
        rx_valid = 1'b0;
        load_start = 1'b0;
        reset = 1'b1;
        dcnt_a = 0;
        dcnt_b = 0;
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
